// File: rtl/serv_databuf_w_if.sv
// Load/store bus side of the serial data buffer: load request/ack handshake,
// read data in, buffer contents and pending flag out.
interface serv_databuf_w_if;
  logic        i_ld_req;
  logic        i_ack;
  logic [31:0] i_dat;
  logic        o_ld_pending;
  logic [31:0] o_dat;

  modport master (
    output i_ld_req,
    output i_ack,
    output i_dat,
    input  o_ld_pending,
    input  o_dat
  );

  modport slave (
    input  i_ld_req,
    input  i_ack,
    input  i_dat,
    output o_ld_pending,
    output o_dat
  );
endinterface

// File: rtl/serv_databuf_w.sv
// W-bit-serial data buffer: operand B select, store data shifting, load capture
// with sign/zero extension, and shift-amount countdown with residual output.
module serv_databuf_w #(
  parameter  int W  = 1,
  localparam int LW = $clog2(W),
  localparam int RW = (LW > 0) ? LW : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_init,
  input  logic          i_cnt_done,
  input  logic [1:0]    i_lsb,
  input  logic          i_byte_valid,
  input  logic          i_op_b_sel,
  input  logic          i_shift_op,
  input  logic          i_signed,
  input  logic [W-1:0]  i_rs2,
  input  logic [W-1:0]  i_imm,
  output logic [W-1:0]  o_op_b,
  output logic [W-1:0]  o_q,
  output logic          o_sh_done,
  output logic          o_sh_done_r,
  output logic [RW-1:0] o_sh_rem,
  serv_databuf_w_if.slave bus
);

  logic [31:0]  dat_reg;
  logic [31:0]  dat_next;
  logic         pend_reg;
  logic         pend_next;
  logic         sign_reg;
  logic         sh_en;
  logic         count_mode;
  logic [5:0]   cnt;
  logic [5:0]   cnt_shift;
  logic [5:0]   cnt_base;
  logic [5:0]   cnt_count;
  logic [W-1:0] op_b;
  logic [W-1:0] byte_sel;

  assign op_b       = i_op_b_sel ? i_rs2 : i_imm;
  assign sh_en      = i_shift_op | (i_en & i_byte_valid);
  assign count_mode = i_shift_op & ~i_init;

  // Plain shift-register field; bit 5 is cleared as init ends so the count
  // phase starts from a non-negative shift amount.
  assign cnt_shift = {dat_reg[W+5] & ~(i_shift_op & i_cnt_done), dat_reg[W+4:W]};

  // Countdown by W per cycle; bit 5 set after the subtract means the count wrapped.
  assign cnt_base  = dat_reg[5:0] & ~6'(W - 1);
  assign cnt_count = cnt_base - 6'(W);
  assign cnt       = count_mode ? cnt_count : cnt_shift;

  assign byte_sel = dat_reg[{i_lsb, 3'b000} +: W];

  always_comb begin
    dat_next  = dat_reg;
    pend_next = pend_reg;
    if (pend_reg) begin
      if (bus.i_ack) begin
        dat_next  = bus.i_dat;
        pend_next = 1'b0;
      end
    end else if (bus.i_ld_req & bus.i_ack) begin
      dat_next = bus.i_dat;
    end else begin
      if (sh_en) begin
        dat_next = {op_b, dat_reg[31:W+6], cnt};
      end
      if (bus.i_ld_req) begin
        pend_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dat_reg  <= '0;
      pend_reg <= 1'b0;
      sign_reg <= 1'b0;
    end else begin
      dat_reg  <= dat_next;
      pend_reg <= pend_next;
      if (i_en & i_byte_valid) begin
        sign_reg <= byte_sel[W-1];
      end
    end
  end

  // The residual is the low bits of the shift amount as it stands after init.
  if (LW > 0) begin : g_rem
    logic [LW-1:0] rem_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rem_reg <= '0;
      end else if (i_shift_op & i_init & i_cnt_done) begin
        rem_reg <= dat_next[LW-1:0];
      end
    end
    assign o_sh_rem = rem_reg;
  end else begin : g_no_rem
    assign o_sh_rem = 1'b0;
  end

  assign o_op_b           = op_b;
  assign o_q              = i_byte_valid ? byte_sel : {W{i_signed & sign_reg}};
  assign o_sh_done        = count_mode & cnt[5];
  assign o_sh_done_r      = dat_reg[5];
  assign bus.o_dat        = dat_reg;
  assign bus.o_ld_pending = pend_reg;

endmodule

// File: tb/tb_serv_databuf_w.sv
// Self-checking bench for serv_databuf_w at W = 1, 2, 4 and 8 sharing one stimulus set.
module tb_serv_databuf_w;

  logic        clk;
  logic        rst_n;
  logic        en, init, cnt_done, byte_valid, op_b_sel, shift_op, sgn;
  logic [1:0]  lsb;
  logic [7:0]  rs2, imm;
  logic        ld_req, ack;
  logic [31:0] bus_dat;

  logic [0:0] op_b1, q1, rem1;
  logic [1:0] op_b2, q2;
  logic [0:0] rem2;
  logic [3:0] op_b4, q4;
  logic [1:0] rem4;
  logic [7:0] op_b8, q8;
  logic [2:0] rem8;
  logic       sh_done1, sh_done2, sh_done4, sh_done8;
  logic       sh_done_r1, sh_done_r2, sh_done_r4, sh_done_r8;

  serv_databuf_w_if bus1();
  serv_databuf_w_if bus2();
  serv_databuf_w_if bus4();
  serv_databuf_w_if bus8();

  assign bus1.i_ld_req = ld_req;
  assign bus1.i_ack    = ack;
  assign bus1.i_dat    = bus_dat;
  assign bus2.i_ld_req = ld_req;
  assign bus2.i_ack    = ack;
  assign bus2.i_dat    = bus_dat;
  assign bus4.i_ld_req = ld_req;
  assign bus4.i_ack    = ack;
  assign bus4.i_dat    = bus_dat;
  assign bus8.i_ld_req = ld_req;
  assign bus8.i_ack    = ack;
  assign bus8.i_dat    = bus_dat;

  serv_databuf_w #(.W(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
    .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
    .i_signed(sgn), .i_rs2(rs2[0:0]), .i_imm(imm[0:0]), .o_op_b(op_b1), .o_q(q1),
    .o_sh_done(sh_done1), .o_sh_done_r(sh_done_r1), .o_sh_rem(rem1), .bus(bus1)
  );

  serv_databuf_w #(.W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
    .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
    .i_signed(sgn), .i_rs2(rs2[1:0]), .i_imm(imm[1:0]), .o_op_b(op_b2), .o_q(q2),
    .o_sh_done(sh_done2), .o_sh_done_r(sh_done_r2), .o_sh_rem(rem2), .bus(bus2)
  );

  serv_databuf_w #(.W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
    .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
    .i_signed(sgn), .i_rs2(rs2[3:0]), .i_imm(imm[3:0]), .o_op_b(op_b4), .o_q(q4),
    .o_sh_done(sh_done4), .o_sh_done_r(sh_done_r4), .o_sh_rem(rem4), .bus(bus4)
  );

  serv_databuf_w #(.W(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
    .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
    .i_signed(sgn), .i_rs2(rs2), .i_imm(imm), .o_op_b(op_b8), .o_q(q8),
    .o_sh_done(sh_done8), .o_sh_done_r(sh_done_r8), .o_sh_rem(rem8), .bus(bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic       sel;
    logic [7:0] rs2;
    logic [7:0] imm;
    logic [1:0] lsb;
    logic       bv;
    logic       sgn;
    logic [7:0] exp_op_b;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic chk_sb(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = sb.pop_front();
      chk(name, act, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] word;
  logic [7:0]  bb;
  logic        b;

  initial begin
    tbl[0] = '{1'b1, 8'h5A, 8'h3C, 2'd0, 1'b1, 1'b0, 8'h5A, 8'h96};
    tbl[1] = '{1'b0, 8'h5A, 8'h3C, 2'd1, 1'b1, 1'b1, 8'h3C, 8'hA5};
    tbl[2] = '{1'b1, 8'hF0, 8'h0F, 2'd2, 1'b1, 1'b0, 8'hF0, 8'hC3};
    tbl[3] = '{1'b0, 8'hF0, 8'h0F, 2'd3, 1'b1, 1'b1, 8'h0F, 8'h00};
    tbl[4] = '{1'b1, 8'h81, 8'h7E, 2'd0, 1'b0, 1'b1, 8'h81, 8'hFF};
    tbl[5] = '{1'b0, 8'h81, 8'h7E, 2'd3, 1'b0, 1'b0, 8'h7E, 8'h00};

    rst_n = 1'b0; en = 0; init = 0; cnt_done = 0; byte_valid = 0; op_b_sel = 0;
    shift_op = 0; sgn = 0; lsb = 0; rs2 = 0; imm = 0; ld_req = 0; ack = 0; bus_dat = 0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dat1", bus1.o_dat, 32'h0);
    chk("rst_dat8", bus8.o_dat, 32'h0);
    chk("rst_pend4", 32'(bus4.o_ld_pending), 32'h0);
    chk("rst_done_r4", 32'(sh_done_r4), 32'h0);
    chk("rst_rem4", 32'(rem4), 32'h0);
    chk("rst_q8", 32'(q8), 32'h0);
    rst_n = 1'b1;

    // W=1 store of 0xDEADBEEF with a random operand select each cycle
    tick();
    word = 32'hDEADBEEF;
    en = 1; byte_valid = 1; lsb = 0;
    for (int k = 0; k < 32; k++) begin
      b        = word[k];
      op_b_sel = 1'($urandom_range(0, 1));
      rs2      = {7'd0, op_b_sel ? b : ~b};
      imm      = {7'd0, op_b_sel ? ~b : b};
      #2;
      chk($sformatf("w1_op_b[%0d]", k), 32'(op_b1), 32'(b));
      tick();
    end
    en = 0; byte_valid = 0;
    #2;
    chk("w1_store", bus1.o_dat, 32'hDEADBEEF);

    // W=4 shift amount 13: init shift-in, then countdown
    tick();
    word = 32'd13; init = 1; shift_op = 1; op_b_sel = 1;
    for (int k = 0; k < 8; k++) begin
      rs2      = {4'd0, word[4*k +: 4]};
      cnt_done = (k == 7);
      tick();
    end
    init = 0; cnt_done = 0;
    #2;
    chk("w4_rem", 32'(rem4), 32'd1);
    chk("w4_done_r_init", 32'(sh_done_r4), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("w4_done_c%0d", c), 32'(sh_done4), 32'(c == 4));
      chk($sformatf("w4_done_r_c%0d", c), 32'(sh_done_r4), 32'd0);
      tick();
      #2;
    end
    chk("w4_done_r_after", 32'(sh_done_r4), 32'd1);
    chk("w4_rem_hold", 32'(rem4), 32'd1);
    shift_op = 0;

    // W=2 load: request, ack three cycles later, dat holds while pending
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    en = 1; byte_valid = 1; op_b_sel = 1; rs2 = 8'hFF; ld_req = 1;
    #1;
    chk("w2_pend_t0", 32'(bus2.o_ld_pending), 32'd0);
    tick();
    ld_req = 0;
    for (int t = 1; t <= 3; t++) begin
      if (t == 3) begin
        ack     = 1;
        bus_dat = 32'h0000_80FF;
        sb.push_back(32'h0000_80FF);
      end
      #2;
      chk($sformatf("w2_pend_t%0d", t), 32'(bus2.o_ld_pending), 32'd1);
      chk($sformatf("w2_hold_t%0d", t), bus2.o_dat, 32'hC000_0000);
      tick();
    end
    ack = 0;
    #2;
    chk("w2_pend_t4", 32'(bus2.o_ld_pending), 32'd0);
    chk_sb("w2_capture", bus2.o_dat);
    en = 0; byte_valid = 0;

    // stray ack with nothing pending is ignored
    tick();
    ack = 1; bus_dat = 32'hFFFF_FFFF;
    tick();
    ack = 0;
    #2;
    chk("w2_stray_ack_dat", bus2.o_dat, 32'h0000_80FF);
    chk("w2_stray_ack_pend", 32'(bus2.o_ld_pending), 32'd0);

    // W=8 request and ack together: capture without pending
    tick();
    ld_req = 1; ack = 1; bus_dat = 32'hC3A5_9611;
    sb.push_back(32'hC3A5_9611);
    #2;
    chk("w8_same_pend_a", 32'(bus8.o_ld_pending), 32'd0);
    tick();
    ld_req = 0; ack = 0;
    #2;
    chk("w8_same_pend_b", 32'(bus8.o_ld_pending), 32'd0);
    chk_sb("w8_same_capture", bus8.o_dat);
    en = 1; byte_valid = 1; lsb = 2; op_b_sel = 0; imm = 8'h00;
    tick();
    en = 0; byte_valid = 0;
    #2;
    chk("w8_shift8", bus8.o_dat, 32'h00C3_A596);

    // table: operand mux and load byte / extension select at W=8 (no state change)
    for (int i = 0; i < 6; i++) begin
      tick();
      op_b_sel = tbl[i].sel; rs2 = tbl[i].rs2; imm = tbl[i].imm;
      lsb = tbl[i].lsb; byte_valid = tbl[i].bv; sgn = tbl[i].sgn;
      #2;
      chk($sformatf("tbl%0d_op_b", i), 32'(op_b8), 32'(tbl[i].exp_op_b));
      chk($sformatf("tbl%0d_q", i), 32'(q8), 32'(tbl[i].exp_q));
    end
    byte_valid = 0; sgn = 0;

    // W=1 signed byte load from offset 1 of 0x00008000
    tick();
    ld_req = 1; ack = 1; bus_dat = 32'h0000_8000;
    tick();
    ld_req = 0; ack = 0;
    en = 1; byte_valid = 1; lsb = 1; sgn = 1; op_b_sel = 0; imm = 8'h00;
    bb = 8'h80;
    for (int k = 0; k < 8; k++) sb.push_back(32'(bb[k]));
    for (int k = 0; k < 8; k++) begin
      #2;
      chk_sb($sformatf("w1_q_bit%0d", k), 32'(q1));
      tick();
    end
    byte_valid = 0;
    #2;
    chk("w1_q_sext", 32'(q1), 32'd1);
    sgn = 0;
    #1;
    chk("w1_q_zext", 32'(q1), 32'd0);
    chk("w1_rem_tied", 32'(rem1), 32'd0);
    en = 0;

    // W=8 asynchronous reset mid-shift with a load pending
    tick();
    ld_req = 1; ack = 1; bus_dat = 32'hFFFF_FFFF;
    tick();
    ack = 0; ld_req = 1; init = 1; shift_op = 1; en = 1; byte_valid = 1; lsb = 3;
    op_b_sel = 1; rs2 = 8'hAB;
    tick();
    ld_req = 0; byte_valid = 0; sgn = 1;
    #2;
    chk("w8_pre_rst_pend", 32'(bus8.o_ld_pending), 32'd1);
    chk("w8_pre_rst_q", 32'(q8), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("w8_rst_dat", bus8.o_dat, 32'h0);
    chk("w8_rst_pend", 32'(bus8.o_ld_pending), 32'd0);
    chk("w8_rst_done_r", 32'(sh_done_r8), 32'd0);
    chk("w8_rst_done", 32'(sh_done8), 32'd0);
    chk("w8_rst_rem", 32'(rem8), 32'd0);
    chk("w8_rst_q", 32'(q8), 32'd0);
    shift_op = 0; init = 0; en = 0;
    tick();
    rst_n = 1'b1;
    ack = 1; bus_dat = 32'h1234_5678;
    tick();
    ack = 0;
    #2;
    chk("w8_post_rst_dat", bus8.o_dat, 32'h0);
    chk("w8_post_rst_pend", 32'(bus8.o_ld_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
